// File: rtl/usb_pkt_tx_sequencer.sv
// USB host transmit sequencer: serialises SYNC, PID, token/data fields and CRC
// LSB first into a raw bit stream for the bit-stuffer/NRZI stage, then drives EOP.
module usb_pkt_tx_sequencer #(
    parameter int PAYLOAD_BITS = 64
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    pkt_valid,
    output logic                    pkt_ready,
    input  logic [3:0]              pkt_pid,
    input  logic [6:0]              pkt_addr,
    input  logic [3:0]              pkt_endp,
    input  logic [PAYLOAD_BITS-1:0] pkt_payload,
    output logic                    bit_out,
    output logic                    bit_valid,
    input  logic                    bit_stall,
    output logic                    eop,
    output logic                    done,
    output logic                    err
);

    localparam int CW = $clog2(PAYLOAD_BITS) + 1;
    localparam int SW = (PAYLOAD_BITS > 16) ? PAYLOAD_BITS : 16;

    localparam logic [CW-1:0] LAST_BYTE  = CW'(7);
    localparam logic [CW-1:0] LAST_TOKEN = CW'(10);
    localparam logic [CW-1:0] LAST_CRC5  = CW'(4);
    localparam logic [CW-1:0] LAST_DATA  = CW'(PAYLOAD_BITS - 1);
    localparam logic [CW-1:0] LAST_CRC16 = CW'(15);
    localparam logic [CW-1:0] LAST_EOP   = CW'(2);
    localparam logic [7:0]    SYNC_PATTERN = 8'h80;

    typedef enum logic [3:0] {
        S_IDLE, S_SYNC, S_PID, S_TOKEN, S_CRC5, S_DATA, S_CRC16, S_EOP, S_DONE, S_ERR
    } state_t;

    state_t                  state, state_d;
    logic [CW-1:0]           cnt, cnt_d, field_end;
    logic [SW-1:0]           sh, sh_d;
    logic [3:0]              pid_q, pid_d;
    logic [10:0]             tok_q, tok_d;
    logic [PAYLOAD_BITS-1:0] pay_q, pay_d;
    logic [4:0]              crc5, crc5_d, crc5_nxt;
    logic [15:0]             crc16, crc16_d, crc16_nxt;
    logic                    field_last, consume;

    function automatic logic is_token(input logic [3:0] pid);
        return (pid == 4'b0001) || (pid == 4'b1001);
    endfunction

    function automatic logic is_data(input logic [3:0] pid);
        return pid == 4'b0011;
    endfunction

    function automatic logic is_handshake(input logic [3:0] pid);
        return (pid == 4'b0010) || (pid == 4'b1010);
    endfunction

    function automatic logic [4:0] rev5(input logic [4:0] v);
        logic [4:0] r;
        for (int i = 0; i < 5; i++) r[i] = v[4-i];
        return r;
    endfunction

    function automatic logic [15:0] rev16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

    // Every field, CRCs included, leaves through sh[0]; the CRCs are loaded
    // bit-reversed and complemented so shifting LSB first sends them MSB first.
    assign bit_valid = state inside {S_SYNC, S_PID, S_TOKEN, S_CRC5, S_DATA, S_CRC16};
    assign bit_out   = bit_valid & sh[0];
    assign consume   = bit_valid & ~bit_stall;

    assign crc5_nxt  = (sh[0] ^ crc5[4])  ? ({crc5[3:0], 1'b0} ^ 5'h05)
                                          : {crc5[3:0], 1'b0};
    assign crc16_nxt = (sh[0] ^ crc16[15]) ? ({crc16[14:0], 1'b0} ^ 16'h8005)
                                           : {crc16[14:0], 1'b0};

    always_comb begin
        field_end = LAST_BYTE;
        case (state)
            S_TOKEN: field_end = LAST_TOKEN;
            S_CRC5:  field_end = LAST_CRC5;
            S_DATA:  field_end = LAST_DATA;
            S_CRC16: field_end = LAST_CRC16;
            S_EOP:   field_end = LAST_EOP;
            default: field_end = LAST_BYTE;
        endcase
    end

    assign field_last = (cnt == field_end);

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        sh_d      = sh;
        pid_d     = pid_q;
        tok_d     = tok_q;
        pay_d     = pay_q;
        crc5_d    = crc5;
        crc16_d   = crc16;
        pkt_ready = 1'b0;
        eop       = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            // DONE also accepts, giving the 4-cycle back-to-back gap.
            S_IDLE, S_DONE: begin
                pkt_ready = 1'b1;
                done      = (state == S_DONE);
                state_d   = S_IDLE;
                if (pkt_valid) begin
                    pid_d   = pkt_pid;
                    tok_d   = {pkt_endp, pkt_addr};
                    pay_d   = pkt_payload;
                    crc5_d  = '1;
                    crc16_d = '1;
                    cnt_d   = '0;
                    sh_d    = SW'(SYNC_PATTERN);
                    state_d = (is_token(pkt_pid) || is_data(pkt_pid) || is_handshake(pkt_pid))
                              ? S_SYNC : S_ERR;
                end
            end
            S_SYNC, S_PID, S_TOKEN, S_CRC5, S_DATA, S_CRC16: begin
                if (consume) begin
                    if (state == S_TOKEN) crc5_d = crc5_nxt;
                    if (state == S_DATA) crc16_d = crc16_nxt;
                    cnt_d = field_last ? '0 : cnt + 1'b1;
                    sh_d  = sh >> 1;
                    if (field_last) begin
                        case (state)
                            S_SYNC: begin
                                state_d = S_PID;
                                sh_d    = SW'({~pid_q, pid_q});
                            end
                            S_PID: begin
                                if (is_token(pid_q)) begin
                                    state_d = S_TOKEN;
                                    sh_d    = SW'(tok_q);
                                end else if (is_data(pid_q)) begin
                                    state_d = S_DATA;
                                    sh_d    = SW'(pay_q);
                                end else begin
                                    state_d = S_EOP;
                                end
                            end
                            S_TOKEN: begin
                                state_d = S_CRC5;
                                sh_d    = SW'(rev5(~crc5_nxt));
                            end
                            S_DATA: begin
                                state_d = S_CRC16;
                                sh_d    = SW'(rev16(~crc16_nxt));
                            end
                            default: state_d = S_EOP;
                        endcase
                    end
                end
            end
            S_EOP: begin
                eop   = 1'b1;
                cnt_d = field_last ? '0 : cnt + 1'b1;
                if (field_last) state_d = S_DONE;
            end
            S_ERR: begin
                err     = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            sh    <= '0;
            pid_q <= '0;
            tok_q <= '0;
            pay_q <= '0;
            crc5  <= '1;
            crc16 <= '1;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            sh    <= sh_d;
            pid_q <= pid_d;
            tok_q <= tok_d;
            pay_q <= pay_d;
            crc5  <= crc5_d;
            crc16 <= crc16_d;
        end
    end

endmodule

// File: tb/tb_usb_pkt_tx_sequencer.sv
// Bench for usb_pkt_tx_sequencer: a packet-level model builds the expected wire
// bit list per descriptor; a negedge monitor checks every consumed bit against it.
module tb_usb_pkt_tx_sequencer;

    localparam int PB = 64;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          pkt_valid = 1'b0;
    logic          pkt_ready;
    logic [3:0]    pkt_pid = '0;
    logic [6:0]    pkt_addr = '0;
    logic [3:0]    pkt_endp = '0;
    logic [PB-1:0] pkt_payload = '0;
    logic          bit_out, bit_valid, eop, done, err;
    logic          bit_stall;

    int n_cmp = 0;
    int n_bad = 0;
    int pkt_bits = 0;
    int done_cnt = 0;
    int stall_pct = 0;
    logic       prev_stall = 1'b0;
    logic       prev_bit = 1'b0;
    logic [0:0] exp_q[$];
    logic [0:0] mdl_q[$];
    logic [0:0] cap_q[$];
    logic [0:0] ref_q[$];
    logic [0:0] e;

    logic [3:0] good_pids [5] = '{4'b0001, 4'b1001, 4'b0011, 4'b0010, 4'b1010};
    logic [3:0] bad_pids  [4] = '{4'b0000, 4'b0110, 4'b1111, 4'b1011};

    usb_pkt_tx_sequencer #(.PAYLOAD_BITS(PB)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .pkt_valid   (pkt_valid),
        .pkt_ready   (pkt_ready),
        .pkt_pid     (pkt_pid),
        .pkt_addr    (pkt_addr),
        .pkt_endp    (pkt_endp),
        .pkt_payload (pkt_payload),
        .bit_out     (bit_out),
        .bit_valid   (bit_valid),
        .bit_stall   (bit_stall),
        .eop         (eop),
        .done        (done),
        .err         (err)
    );

    // Clock and watchdog
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Downstream stall generator
    initial begin
        bit_stall = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            bit_stall = ($urandom_range(99) < stall_pct);
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, want, $time);
        end
    endtask

    function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
        return (c[4] ^ b) ? ({c[3:0], 1'b0} ^ 5'h05) : {c[3:0], 1'b0};
    endfunction

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        return (c[15] ^ b) ? ({c[14:0], 1'b0} ^ 16'h8005) : {c[14:0], 1'b0};
    endfunction

    function automatic logic [63:0] pack(input int lo, input int n);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = mdl_q[lo+i];
        return v;
    endfunction

    // Wire-level bit list of a whole packet; empty for an unsupported PID.
    task automatic model_build(input logic [3:0] pid, input logic [6:0] addr,
                               input logic [3:0] endp, input logic [PB-1:0] pay);
        logic [4:0]  c5;
        logic [15:0] c16;
        logic [10:0] tok;
        mdl_q.delete();
        if (!(pid inside {4'b0001, 4'b1001, 4'b0011, 4'b0010, 4'b1010})) return;
        for (int i = 0; i < 7; i++) mdl_q.push_back(1'b0);
        mdl_q.push_back(1'b1);
        for (int i = 0; i < 4; i++) mdl_q.push_back(pid[i]);
        for (int i = 0; i < 4; i++) mdl_q.push_back(~pid[i]);
        if (pid == 4'b0001 || pid == 4'b1001) begin
            tok = {endp, addr};
            c5 = 5'h1F;
            for (int i = 0; i < 11; i++) begin
                mdl_q.push_back(tok[i]);
                c5 = crc5_step(c5, tok[i]);
            end
            for (int i = 4; i >= 0; i--) mdl_q.push_back(~c5[i]);
        end else if (pid == 4'b0011) begin
            c16 = 16'hFFFF;
            for (int i = 0; i < PB; i++) begin
                mdl_q.push_back(pay[i]);
                c16 = crc16_step(c16, pay[i]);
            end
            for (int i = 15; i >= 0; i--) mdl_q.push_back(~c16[i]);
        end
    endtask

    // Per-cycle compare process
    always @(negedge clock) begin
        if (done) done_cnt++;
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_valid", bit_valid, 1);
                check("stall_hold_bit", bit_out, prev_bit);
            end
            if (bit_valid) begin
                check("valid_while_ready", pkt_ready, 0);
                check("valid_with_eop", eop, 0);
                if (!bit_stall) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL extra_bit: got bit %0b with no expected bit at t=%0t", bit_out, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("bit", bit_out, e);
                    end
                    cap_q.push_back(bit_out);
                    pkt_bits++;
                end
            end else begin
                check("idle_bit_out", bit_out, 0);
            end
            prev_stall = bit_valid && bit_stall;
            prev_bit   = bit_out;
        end
    end

    // Driver tasks
    task automatic send(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp,
                        input logic [PB-1:0] pay, input bit b2b, output int nb);
        int w;
        if (!b2b) @(negedge clock);
        w = 0;
        while (!pkt_ready && w < 300) begin
            @(negedge clock);
            w++;
        end
        check("ready_to_accept", pkt_ready, 1);
        model_build(pid, addr, endp, pay);
        foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
        nb = mdl_q.size();
        cap_q.delete();
        pkt_bits    = 0;
        pkt_valid   = 1'b1;
        pkt_pid     = pid;
        pkt_addr    = addr;
        pkt_endp    = endp;
        pkt_payload = pay;
        @(posedge clock);
        #1;
    endtask

    task automatic run_pkt(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp,
                           input logic [PB-1:0] pay, input bit noise, input bit b2b);
        int nb, k, st, eops;
        bit seen;
        send(pid, addr, endp, pay, b2b, nb);
        if (!noise) pkt_valid = 1'b0;
        k = 0; st = 0; eops = 0; seen = 0;
        while (!seen && k < 1000) begin
            @(negedge clock);
            k++;
            if (noise) begin
                if (k < 4) begin
                    pkt_pid     = 4'($urandom);
                    pkt_addr    = 7'($urandom);
                    pkt_endp    = 4'($urandom);
                    pkt_payload = {$urandom, $urandom};
                end else begin
                    pkt_valid = 1'b0;
                end
            end
            if (bit_valid && bit_stall) st++;
            if (eop) eops++;
            if (done) seen = 1;
        end
        check("done_seen", seen, 1);
        check("done_cycle", k, nb + st + 4);
        check("eop_cycles", eops, 3);
        check("ready_at_done", pkt_ready, 1);
        check("bits_left", exp_q.size(), 0);
    endtask

    task automatic run_bad(input logic [3:0] pid);
        int nb;
        send(pid, 7'($urandom), 4'($urandom), '0, 1'b0, nb);
        pkt_valid = 1'b0;
        check("bad_model_bits", nb, 0);
        @(negedge clock);
        check("err_t1", err, 1);
        check("bad_valid_t1", bit_valid, 0);
        check("bad_ready_t1", pkt_ready, 0);
        @(negedge clock);
        check("err_t2", err, 0);
        check("bad_valid_t2", bit_valid, 0);
        check("bad_ready_t2", pkt_ready, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, pkt_ready, 1);
        check({tag, "_bit_valid"}, bit_valid, 0);
        check({tag, "_bit_out"}, bit_out, 0);
        check({tag, "_eop"}, eop, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic reset_abort();
        int nb, base, w;
        send(4'b0011, 7'd0, 4'd0, {$urandom, $urandom}, 1'b0, nb);
        pkt_valid = 1'b0;
        base = done_cnt;
        w = 0;
        while (pkt_bits < 56 && w < 500) begin
            @(posedge clock);
            #1;
            w++;
        end
        check("abort_at_data_bit40", pkt_bits, 56);
        #1 reset_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        exp_q.delete();
        repeat (3) @(negedge clock);
        check("abort_no_done", done_cnt, base);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [4:0]  r5;
        logic [15:0] r16;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        run_pkt(4'b0010, 7'd0, 4'd0, '0, 1'b0, 1'b0);
        check("ack_model_bits", pack(0, 16), 64'hD280);

        run_pkt(4'b0001, 7'd5, 4'd4, '0, 1'b0, 1'b0);
        check("out_model_len", mdl_q.size(), 32);
        check("out_model_pid", pack(8, 8), 64'hE1);
        check("out_model_field", pack(16, 11), 64'h205);
        r5 = 5'h1F;
        for (int i = 16; i < 32; i++) r5 = crc5_step(r5, mdl_q[i]);
        check("out_crc5_residue", r5, 5'h0C);

        run_pkt(4'b0011, 7'd0, 4'd0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
        check("data_model_len", mdl_q.size(), 96);
        r16 = 16'hFFFF;
        for (int i = 16; i < 96; i++) r16 = crc16_step(r16, mdl_q[i]);
        check("data_crc16_residue", r16, 16'h800D);

        run_pkt(4'b1001, 7'h3A, 4'hB, '0, 1'b0, 1'b0);
        ref_q = cap_q;
        stall_pct = 30;
        run_pkt(4'b1001, 7'h3A, 4'hB, '0, 1'b0, 1'b0);
        stall_pct = 0;
        check("in_stall_len", cap_q.size(), ref_q.size());
        for (int i = 0; i < ref_q.size() && i < cap_q.size(); i++)
            check("in_stall_seq", cap_q[i], ref_q[i]);

        run_bad(4'b1111);
        run_pkt(4'b1010, 7'd0, 4'd0, '0, 1'b0, 1'b0);

        reset_abort();
        run_pkt(4'b0010, 7'd0, 4'd0, '0, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            int sel;
            sel = $urandom_range(5);
            stall_pct = ($urandom_range(1) == 1) ? 30 : 0;
            if (sel == 5)
                run_bad(bad_pids[$urandom_range(3)]);
            else
                run_pkt(good_pids[sel], 7'($urandom), 4'($urandom), {$urandom, $urandom},
                        1'($urandom_range(1)), 1'($urandom_range(1)));
        end
        stall_pct = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/usb_pkt_tx_sequencer.md
Name: usb_pkt_tx_sequencer

Overview:
Transmit-side controller for the USB host. Accepts one packet descriptor at a time and sequences SYNC, PID, the token or data fields, and the CRC into a serial raw bit stream. It then signals EOP. Output feeds the downstream bit-stuffer/NRZI stage, which can stall the stream; the block owns the shift, count and CRC datapath for the packet.

Parameters:
PAYLOAD_BITS, 64, data-packet payload width in bits; must be a multiple of 8.

Ports:
clock  input  1  system clock
reset_n  input  1  reset
pkt_valid  input  1  descriptor valid
pkt_ready  output  1  sequencer idle and able to accept
pkt_pid  input  4  PID nibble
pkt_addr  input  7  device address (tokens only)
pkt_endp  input  4  endpoint (tokens only)
pkt_payload  input  PAYLOAD_BITS  data payload (DATA0 only)
bit_out  output  1  current serial bit
bit_valid  output  1  bit_out meaningful
bit_stall  input  1  downstream not consuming this cycle (stuff-bit insertion)
eop  output  1  drive SE0/idle EOP sequence this cycle
done  output  1  one-cycle pulse, packet complete
err  output  1  one-cycle pulse, unsupported PID rejected

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clock. In reset: state IDLE, pkt_ready=1, bit_out=0, bit_valid=0, eop=0, done=0, err=0, CRC registers=all ones, counters=0.
- An asserted reset mid-packet aborts it immediately with no done pulse.
- Accept: pkt_valid && pkt_ready at edge T latches all descriptor fields and clears pkt_ready. The first SYNC bit appears with bit_valid=1 in cycle T+1.
- Consume rule: a bit is consumed on each edge where bit_valid && !bit_stall.
  - While bit_stall=1, the sequencer holds bit_out, state, counters and CRC.
  - bit_stall is ignored outside the bit-emitting states.
- Packet class from pkt_pid:
  - Token: OUT 0001, IN 1001.
  - Data: DATA0 0011.
  - Handshake: ACK 0010, NAK 1010.
  - Any other PID: no bits are emitted, err pulses at T+1, and the block returns to IDLE with pkt_ready=1 at T+2.
- States: IDLE -> SYNC -> PID -> {TOKEN -> CRC5 | DATA -> CRC16 | (handshake) } -> EOP -> DONE -> IDLE.
- Bit ordering: all fields are sent LSB first.
  - SYNC is 8'b1000_0000 on the wire: seven 0s then a 1.
  - PID byte is {~pid, pid}.
  - TOKEN sends addr[0..6], then endp[0..3]: 11 bits.
  - DATA sends payload[0..PAYLOAD_BITS-1].
- CRC5:
  - Polynomial x^5+x^2+1, init 5'b11111, updated on each consumed TOKEN bit.
  - Transmitted as the one's complement of the residue, MSB first, 5 bits.
- CRC16:
  - Polynomial 0x8005, init 16'hFFFF, updated on each consumed DATA bit.
  - Transmitted complemented, MSB first, 16 bits.
- Bits per packet:
  - Handshake: 16.
  - Token: 32.
  - Data: 32+PAYLOAD_BITS (96 at default).
  - Field counters are sized to $clog2(PAYLOAD_BITS)+1 bits and never wrap within a field.
- Field transitions: when the last bit of a field is consumed, the first bit of the next field is presented in the next cycle, with no bubble (bit_valid stays 1).
- EOP:
  - Follows the last consumed bit.
  - eop=1 for exactly 3 cycles (SE0, SE0, J) with bit_valid=0; stall is ignored.
- DONE: done=1 for one cycle. pkt_ready returns to 1 in the same cycle, so a new packet may be accepted at that edge. The back-to-back gap is therefore 4 cycles after the last bit.
- pkt_valid while busy: ignored; fields are not re-latched.

Test Plan:
- Reset, then ACK (pid 0010), no stall -> 16 consumed bits, 0000000 1 followed by 0,1,0,0,1,0,1,1 (0xD2 LSB first). Then eop for 3 cycles, done at cycle T+20, pkt_ready high at the same cycle.
- OUT token, addr=7'd5, endp=4'd4 -> PID bits of 0xE1 LSB first, then 11 field bits 1,0,1,0,0,0,0 / 0,0,1,0. Then 5 CRC5 bits equal to the golden model's ~crc5. 32 bits total, err=0.
- DATA0, payload=64'h0123_4567_89AB_CDEF -> 96 bits. CRC16 field equals the golden model. Receiver-side CRC16 check over payload+crc yields residue 16'h800D.
- IN token with bit_stall asserted randomly at 30% -> identical consumed bit sequence to the unstalled run. bit_out stable across every stalled cycle; no bit lost or duplicated.
- pid=4'b1111 -> err pulse at T+1, bit_valid never rises, pkt_ready=1 at T+2. A following valid NAK is transmitted correctly.
- Reset asserted during DATA bit 40 -> all outputs at reset values asynchronously and no done. The next ACK after deassertion is transmitted correctly.
